// File: rtl/alu_rr_scheduler_pkg.sv
// Purpose : shared definitions for the round-robin ALU scheduler: opcodes and FSM states.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_rr_scheduler_pkg;

   // ALU opcodes (3-bit)
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_EQ  = 3'b111;

   // Scheduler FSM: accept -> compute -> present response
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Only add and subtract produce a meaningful carry-out.
   function automatic logic op_has_carry(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_alu4_comb.sv
// Purpose : purely combinational ALU (add/sub/not/and/or/xor/slt/eq) with carry-out.
// Latency : 0 cycles (combinational).
// Backpressure: none; the caller registers the outputs.
// Ports   : op (3b opcode), a/b (W-bit operands) -> result (W-bit), carry (1b).
module alu4_comb
   import alu_rr_scheduler_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         carry
);

   logic [W:0]   sum;
   logic [W-1:0] b_neg;

   always_comb begin
      // Two's complement of b, wrapped to W bits (b=0 gives 0, so a-0 has no carry).
      b_neg  = ~b + W'(1);
      sum    = '0;
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: sum = {1'b0, a} + {1'b0, b};
         OP_SUB: sum = {1'b0, a} + {1'b0, b_neg};
         default: sum = '0;
      endcase
      case (op)
         OP_ADD,
         OP_SUB:  result = sum[W-1:0];
         OP_NOT:  result = ~a;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = ($signed(a) < $signed(b)) ? W'(1) : '0;
         OP_EQ:   result = (a == b) ? W'(1) : '0;
         default: result = '0;
      endcase
      carry = op_has_carry(op) ? sum[W] : 1'b0;
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Purpose : shares one ALU among NREQ requesters with round-robin arbitration.
// Latency : accept at cycle T -> rsp_valid at T+2; 3 cycles/op with rsp_ready held high.
// Backpressure: response held stable until rsp_ready; no new grant while a response is pending.
// Ports   : clk/rst (sync, active-high); req_valid/req_ready/req_op/req_a/req_b per requester
//           (flattened, slice i); rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_carry response channel.
module alu_rr_scheduler
   import alu_rr_scheduler_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int W    = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*3-1:0] req_op,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_result,
   output logic              rsp_carry
);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] rr_ptr;

   // Operands captured at accept time; requesters are free to move on afterwards.
   logic [2:0]     op_lat;
   logic [W-1:0]   a_lat;
   logic [W-1:0]   b_lat;
   logic [IDW-1:0] id_lat;

   logic           grant_vld;
   logic [IDW-1:0] grant_id;
   int             scan_idx;

   logic [W-1:0]   alu_result;
   logic           alu_carry;

   // Round-robin scan: first valid requester starting at rr_ptr, wrapping mod NREQ.
   // NREQ need not be a power of two, so the wrap is an explicit modulo.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = (int'(rr_ptr) + k) % NREQ;
         if (!grant_vld && req_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(scan_idx);
         end
      end
   end

   // Next-state and grant. A grant is only ever issued to a valid requester,
   // so issuing it always completes the handshake in the same cycle.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         ST_IDLE: begin
            if (grant_vld) begin
               req_ready[grant_id] = 1'b1;
               state_nxt           = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rsp_valid = (state == ST_RESP);

   alu4_comb #(
      .W (W)
   ) u_alu (
      .op     (op_lat),
      .a      (a_lat),
      .b      (b_lat),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Reset abandons any in-flight op: FSM returns to IDLE and no response is produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         op_lat     <= '0;
         a_lat      <= '0;
         b_lat      <= '0;
         id_lat     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && grant_vld) begin
            op_lat <= req_op[int'(grant_id)*3 +: 3];
            a_lat  <= req_a[int'(grant_id)*W +: W];
            b_lat  <= req_b[int'(grant_id)*W +: W];
            id_lat <= grant_id;
            rr_ptr <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + IDW'(1);
         end
         // Response registers load only here, so they stay frozen throughout RESP.
         if (state == ST_EXEC) begin
            rsp_id     <= id_lat;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
         end
      end
   end

endmodule
